lp805x_randchk: RTL and testbench
=================================

// Module: lp805x_randchk
// PURPOSE
//  Receive-side checker for the lp805x_rand 32-bit LFSR number stream.
//  Self-seeds from the first non-zero word it receives and predicts every later word.
//  Compares each word against the prediction, then reports lock status and errors.
//  Sits on the consumer side of number_o: in BIST logic or a bench monitor next to the core.
// PARAMETERS
//  POLY      32'h80200003  Galois feedback mask; next(s) = {s[30:0],1'b0} ^ (s[31] ? POLY : 0)
//  LOCK_CNT  4             consecutive matches needed in VERIFY before LOCKED (1..15)
//  MISS_MAX  3             consecutive mismatches in LOCKED before dropping to HUNT (1..15)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low (0 = reset)
//  valid_i      in   1   number_i carries a new generator word this cycle
//  number_i     in   32  word from generator
//  resync_i     in   1   one-cycle request to drop lock and re-hunt
//  locked_o     out  1   1 while FSM is in LOCKED
//  err_o        out  1   one-cycle pulse: mismatch detected in LOCKED
//  err_cnt_o    out  16  saturating count of LOCKED mismatches
//  state_o      out  2   00 HUNT, 01 VERIFY, 10 LOCKED
// BEHAVIOUR
//  Reset (reset=0, async): state=HUNT, expected=0, run counter=0, locked_o=0, err_o=0,
//   err_cnt_o=0. All outputs are registered. A word sampled on edge N is reflected on
//   the outputs after edge N (1-cycle latency).
//  Input words are evaluated only when valid_i=1. When valid_i=0, all state holds and err_o=0.
//  HUNT: a non-zero word W moves the FSM to VERIFY with expected<=next(W) and run=0.
//   W==0 is the LFSR lock-up value; it is ignored and the FSM stays in HUNT.
//  VERIFY:
//   - match (W==expected): run++ and expected<=next(expected).
//     When run reaches LOCK_CNT, go to LOCKED and set run=0.
//   - mismatch: reseed. If W!=0, expected<=next(W), run=0, stay in VERIFY.
//     If W==0, go to HUNT.
//   - err_o is never asserted in VERIFY.
//  LOCKED (flywheel): expected<=next(expected) on every valid word, match or not.
//   The checker never reseeds from data while LOCKED.
//   - match: miss run=0.
//   - mismatch: err_o=1 for one cycle, err_cnt_o+1 (holds at 16'hFFFF), miss run+1.
//     When the miss run reaches MISS_MAX, go to HUNT. That word's error is still counted.
//  resync_i=1: go to HUNT, run=0, expected=0. The same-cycle valid word is discarded.
//   err_cnt_o is not cleared; only reset clears it.
//  resync_i and valid_i in the same cycle: resync wins.
//  Back-to-back valid words, one per cycle, are supported at full rate with no stall.
//  Reset mid-operation: immediate return to the reset values above, whatever the state.
// TESTING
//  1 Reset, then words 1,2,4,8,16 each with valid_i=1: VERIFY after word 1,
//    LOCKED (locked_o=1) one cycle after word 16, err_cnt_o=0.
//  2 Locked near the top bit, word 32'h80000000 then 32'h80200003:
//    both match, err_o stays 0 (checks POLY feedback).
//  3 While LOCKED, send one corrupted word 32'h12345678 in place of the expected word,
//    then correct sequence: err_o pulses once, err_cnt_o=1, stays LOCKED.
//  4 While LOCKED, 3 consecutive wrong words: err_cnt_o +3, state_o=00 (HUNT) after the
//    3rd; then a new valid sequence relocks after 1+LOCK_CNT words.
//  5 In HUNT, feed words 0,0,5: stays HUNT for the zeros, VERIFY after 5.
//    In VERIFY, a wrong word reseeds with no err_o.
//  6 resync_i asserted with valid_i in LOCKED: HUNT next cycle, word discarded, err_cnt_o
//    kept. Assert reset mid-VERIFY: all outputs 0 at once.
//    Force 65536 errors: err_cnt_o saturates at 16'hFFFF.

Source files
------------

// File: rtl/lp805x_randchk_if.sv
// Receive-side stream bus into the LFSR checker: one generator word per valid cycle,
// plus a one-cycle resync request. There is no ready; the checker accepts every valid word.
interface lp805x_randchk_if;
    logic        valid_i;
    logic [31:0] number_i;
    logic        resync_i;

    modport master (output valid_i, output number_i, output resync_i);
    modport slave  (input  valid_i, input  number_i, input  resync_i);
endinterface

// File: rtl/lp805x_randchk.sv
// Checker for the lp805x_rand Galois LFSR stream: seeds from the first non-zero word,
// confirms the seed over LOCK_CNT matches, then flywheels and counts mismatches.
module lp805x_randchk #(
    parameter logic [31:0] POLY     = 32'h80200003,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned MISS_MAX = 3
) (
    input  logic                clk,
    input  logic                reset,
    lp805x_randchk_if.slave     rx,
    output logic                locked_o,
    output logic                err_o,
    output logic [15:0]         err_cnt_o,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_e;

    localparam logic [3:0] LOCK_N = LOCK_CNT[3:0];
    localparam logic [3:0] MISS_N = MISS_MAX[3:0];

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        lfsr_next = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
    endfunction

    state_e      state_q;
    logic [31:0] exp_q;
    logic [3:0]  run_q;
    logic [3:0]  miss_q;
    logic        locked_q;
    logic        err_q;
    logic [15:0] err_cnt_q;
    logic [15:0] err_cnt_d;
    logic        match;

    assign match     = (rx.number_i == exp_q);
    assign err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= HUNT;
            exp_q     <= 32'h0;
            run_q     <= 4'd0;
            miss_q    <= 4'd0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 16'h0;
        end else begin
            err_q <= 1'b0;
            // Resync beats a same-cycle word; the error count survives it.
            if (rx.resync_i) begin
                state_q  <= HUNT;
                exp_q    <= 32'h0;
                run_q    <= 4'd0;
                miss_q   <= 4'd0;
                locked_q <= 1'b0;
            end else if (rx.valid_i) begin
                case (state_q)
                    HUNT: begin
                        if (rx.number_i != 32'h0) begin
                            state_q <= VERIFY;
                            exp_q   <= lfsr_next(rx.number_i);
                            run_q   <= 4'd0;
                        end
                    end
                    VERIFY: begin
                        if (match) begin
                            exp_q <= lfsr_next(exp_q);
                            if (run_q + 4'd1 == LOCK_N) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                run_q    <= 4'd0;
                                miss_q   <= 4'd0;
                            end else begin
                                run_q <= run_q + 4'd1;
                            end
                        end else if (rx.number_i != 32'h0) begin
                            exp_q <= lfsr_next(rx.number_i);
                            run_q <= 4'd0;
                        end else begin
                            state_q <= HUNT;
                            exp_q   <= 32'h0;
                            run_q   <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: the prediction advances regardless of the data.
                        exp_q <= lfsr_next(exp_q);
                        if (match) begin
                            miss_q <= 4'd0;
                        end else begin
                            err_q     <= 1'b1;
                            err_cnt_q <= err_cnt_d;
                            if (miss_q + 4'd1 == MISS_N) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                                miss_q   <= 4'd0;
                                run_q    <= 4'd0;
                            end else begin
                                miss_q <= miss_q + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked_o  = locked_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_lp805x_randchk.sv
// Directed bench for lp805x_randchk: lock-up, POLY feedback, flywheel errors, relock,
// resync, async reset and counter saturation (on a second instance with MISS_MAX=15).
module tb_lp805x_randchk;

    logic        clk;
    logic        reset;
    logic        locked, err, s_locked, s_err;
    logic [15:0] err_cnt, s_err_cnt;
    logic [1:0]  state, s_state;
    int          total;
    int          bad;

    lp805x_randchk_if bus();
    lp805x_randchk_if sbus();

    lp805x_randchk dut (
        .clk(clk), .reset(reset), .rx(bus),
        .locked_o(locked), .err_o(err), .err_cnt_o(err_cnt), .state_o(state)
    );

    lp805x_randchk #(.MISS_MAX(15)) u_sat (
        .clk(clk), .reset(reset), .rx(sbus),
        .locked_o(s_locked), .err_o(s_err), .err_cnt_o(s_err_cnt), .state_o(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_next(input logic [31:0] s);
        ref_next = {s[30:0], 1'b0} ^ (s[31] ? 32'h80200003 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic lk,
                           input logic er, input logic [15:0] cnt);
        chk({tag, ".state"}, {30'h0, state}, {30'h0, st});
        chk({tag, ".locked"}, {31'h0, locked}, {31'h0, lk});
        chk({tag, ".err"}, {31'h0, err}, {31'h0, er});
        chk({tag, ".cnt"}, {16'h0, err_cnt}, {16'h0, cnt});
    endtask

    task automatic step(input logic v, input logic [31:0] w, input logic rs);
        @(negedge clk);
        bus.valid_i  = v;
        bus.number_i = w;
        bus.resync_i = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic sstep(input logic v, input logic [31:0] w);
        @(negedge clk);
        sbus.valid_i  = v;
        sbus.number_i = w;
        sbus.resync_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] sexp;
        int          errs;
        int          k;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.valid_i = 1'b0;  bus.number_i = 32'h0;  bus.resync_i = 1'b0;
        sbus.valid_i = 1'b0; sbus.number_i = 32'h0; sbus.resync_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 2'b00, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        reset = 1'b1;

        // Seed with 1, confirm with 2,4,8,16.
        step(1'b1, 32'h1, 1'b0);
        chk_all("t1.seed", 2'b01, 1'b0, 1'b0, 16'h0);
        step(1'b1, 32'h2, 1'b0);
        step(1'b1, 32'h4, 1'b0);
        step(1'b1, 32'h8, 1'b0);
        chk_all("t1.run3", 2'b01, 1'b0, 1'b0, 16'h0);
        step(1'b1, 32'h10, 1'b0);
        chk_all("t1.lock", 2'b10, 1'b1, 1'b0, 16'h0);

        // Idle cycles must hold state and the prediction.
        step(1'b0, 32'hFFFF_FFFF, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk_all("idle", 2'b10, 1'b1, 1'b0, 16'h0);

        // Walk the single bit up to the top, then through the POLY feedback.
        for (int i = 5; i < 31; i++) begin
            step(1'b1, 32'h1 << i, 1'b0);
            chk("t2.walk.err", {31'h0, err}, 32'h0);
        end
        step(1'b1, 32'h8000_0000, 1'b0);
        chk_all("t2.top", 2'b10, 1'b1, 1'b0, 16'h0);
        step(1'b1, 32'h8020_0003, 1'b0);
        chk_all("t2.poly", 2'b10, 1'b1, 1'b0, 16'h0);

        // One corrupted word in place of 80600005, then 80E00009 resumes.
        step(1'b1, 32'h1234_5678, 1'b0);
        chk_all("t3.bad", 2'b10, 1'b1, 1'b1, 16'd1);
        step(1'b1, 32'h80E0_0009, 1'b0);
        chk_all("t3.good", 2'b10, 1'b1, 1'b0, 16'd1);

        // Three misses in a row drop to HUNT, all three counted.
        step(1'b1, 32'hDEAD_BEEF, 1'b0);
        chk_all("t4.miss1", 2'b10, 1'b1, 1'b1, 16'd2);
        step(1'b1, 32'hCAFE_F00D, 1'b0);
        chk_all("t4.miss2", 2'b10, 1'b1, 1'b1, 16'd3);
        step(1'b1, 32'h0, 1'b0);
        chk_all("t4.miss3", 2'b00, 1'b0, 1'b1, 16'd4);
        step(1'b1, 32'h3, 1'b0);
        chk_all("t4.seed", 2'b01, 1'b0, 1'b0, 16'd4);
        step(1'b1, 32'h6, 1'b0);
        step(1'b1, 32'hC, 1'b0);
        step(1'b1, 32'h18, 1'b0);
        chk_all("t4.run3", 2'b01, 1'b0, 1'b0, 16'd4);
        step(1'b1, 32'h30, 1'b0);
        chk_all("t4.relock", 2'b10, 1'b1, 1'b0, 16'd4);

        // Resync with the correct next word (0x60): discarded, count kept.
        step(1'b1, 32'h60, 1'b1);
        chk_all("t6.resync", 2'b00, 1'b0, 1'b0, 16'd4);

        // Zeros ignored in HUNT; 5 seeds; wrong word reseeds silently.
        step(1'b1, 32'h0, 1'b0);
        step(1'b1, 32'h0, 1'b0);
        chk_all("t5.zeros", 2'b00, 1'b0, 1'b0, 16'd4);
        step(1'b1, 32'h5, 1'b0);
        chk_all("t5.seed", 2'b01, 1'b0, 1'b0, 16'd4);
        step(1'b1, 32'h7, 1'b0);
        chk_all("t5.reseed", 2'b01, 1'b0, 1'b0, 16'd4);
        step(1'b1, 32'hE, 1'b0);
        step(1'b1, 32'h1C, 1'b0);
        step(1'b1, 32'h38, 1'b0);
        chk_all("t5.run3", 2'b01, 1'b0, 1'b0, 16'd4);
        step(1'b1, 32'h70, 1'b0);
        chk_all("t5.lock", 2'b10, 1'b1, 1'b0, 16'd4);

        // Bare resync, reseed, then async reset mid-VERIFY.
        step(1'b0, 32'h0, 1'b1);
        chk_all("t6.resync2", 2'b00, 1'b0, 1'b0, 16'd4);
        step(1'b1, 32'h5, 1'b0);
        chk_all("t6.verify", 2'b01, 1'b0, 1'b0, 16'd4);
        step(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("t6.async_rst", 2'b00, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        reset = 1'b1;

        // Saturation on the MISS_MAX=15 instance: 14 misses then one match, repeated.
        sstep(1'b1, 32'h1);
        sstep(1'b1, 32'h2);
        sstep(1'b1, 32'h4);
        sstep(1'b1, 32'h8);
        sstep(1'b1, 32'h10);
        chk("sat.lock", {30'h0, s_state}, 32'h2);
        sexp = 32'h20;
        errs = 0;
        k    = 0;
        while (errs < 65537) begin
            if (k % 15 == 14) begin
                sstep(1'b1, sexp);
            end else begin
                sstep(1'b1, ~sexp);
                errs++;
                if (errs == 65534) chk("sat.fffe", {16'h0, s_err_cnt}, 32'hFFFE);
            end
            sexp = ref_next(sexp);
            k++;
        end
        chk("sat.cnt", {16'h0, s_err_cnt}, 32'hFFFF);
        chk("sat.state", {30'h0, s_state}, 32'h2);
        chk("sat.err", {31'h0, s_err}, 32'h1);
        chk("sat.locked", {31'h0, s_locked}, 32'h1);
        sstep(1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
